// File: rtl/cache_line_fill.sv
// Cache miss line fill engine: four critical-word-first bus reads, early critical
// word forward, then the assembled 128-bit line in cache-line order (L0 in the top bits).
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a miss request; the bus is idle
// S_FETCH | bus read in flight; words are collected in wrap order
module cache_line_fill #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         i_clk,
    input  logic         i_nreset,
    input  logic         i_req,
    input  logic [31:0]  i_req_addr,
    output logic         o_req_ack,
    output logic         o_cw_valid,
    output logic [31:0]  o_cw_data,
    output logic         o_line_valid,
    output logic         o_line_err,
    output logic [27:0]  o_line_addr,
    output logic [127:0] o_line_data,
    output logic         o_bus_req,
    output logic [31:0]  o_bus_addr,
    input  logic         i_bus_ack,
    input  logic         i_bus_err,
    input  logic [31:0]  i_bus_data
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [0:0]    r_state;
    logic [1:0]    r_ptr;
    logic [1:0]    r_remain;
    logic [WW-1:0] r_wait;
    logic          r_req_ack;
    logic          r_cw_valid;
    logic [31:0]   r_cw_data;
    logic          r_line_valid;
    logic          r_line_err;
    logic [27:0]   r_line_addr;
    logic [127:0]  r_line_data;
    logic          r_bus_req;
    logic [31:0]   r_bus_addr;

    logic [1:0]    w_next_ptr;
    logic          w_timeout;
    logic          w_err;
    logic          w_unused;

    assign w_next_ptr = r_ptr + 2'd1;
    // The read is abandoned on the cycle the wait count would reach TIMEOUT.
    assign w_timeout  = (TIMEOUT != 0) && !i_bus_ack && !i_bus_err &&
                        (32'(r_wait) == TIMEOUT - 32'd1);
    assign w_err      = i_bus_err || w_timeout;
    assign w_unused   = ^i_req_addr[1:0];

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_state      <= S_IDLE;
            r_ptr        <= 2'd0;
            r_remain     <= 2'd0;
            r_wait       <= '0;
            r_req_ack    <= 1'b0;
            r_cw_valid   <= 1'b0;
            r_cw_data    <= 32'd0;
            r_line_valid <= 1'b0;
            r_line_err   <= 1'b0;
            r_line_addr  <= 28'd0;
            r_line_data  <= 128'd0;
            r_bus_req    <= 1'b0;
            r_bus_addr   <= 32'd0;
        end else begin
            r_req_ack    <= 1'b0;
            r_cw_valid   <= 1'b0;
            r_line_valid <= 1'b0;
            r_line_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_state     <= S_FETCH;
                        r_line_addr <= i_req_addr[31:4];
                        r_ptr       <= i_req_addr[3:2];
                        r_remain    <= 2'd3;
                        r_wait      <= '0;
                        r_req_ack   <= 1'b1;
                        r_bus_req   <= 1'b1;
                        r_bus_addr  <= {i_req_addr[31:2], 2'b00};
                    end
                end
                S_FETCH: begin
                    if (w_err) begin
                        r_line_err <= 1'b1;
                        r_bus_req  <= 1'b0;
                        r_wait     <= '0;
                        r_state    <= S_IDLE;
                    end else if (i_bus_ack) begin
                        case (r_ptr)
                            2'd0:    r_line_data[127:96] <= i_bus_data;
                            2'd1:    r_line_data[95:64]  <= i_bus_data;
                            2'd2:    r_line_data[63:32]  <= i_bus_data;
                            default: r_line_data[31:0]   <= i_bus_data;
                        endcase
                        if (r_remain == 2'd3) begin
                            r_cw_valid <= 1'b1;
                            r_cw_data  <= i_bus_data;
                        end
                        r_ptr      <= w_next_ptr;
                        r_remain   <= r_remain - 2'd1;
                        r_wait     <= '0;
                        r_bus_addr <= {r_line_addr, w_next_ptr, 2'b00};
                        if (r_remain == 2'd0) begin
                            r_line_valid <= 1'b1;
                            r_bus_req    <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end else if (TIMEOUT != 0) begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ack    = r_req_ack;
    assign o_cw_valid   = r_cw_valid;
    assign o_cw_data    = r_cw_data;
    assign o_line_valid = r_line_valid;
    assign o_line_err   = r_line_err;
    assign o_line_addr  = r_line_addr;
    assign o_line_data  = r_line_data;
    assign o_bus_req    = r_bus_req;
    assign o_bus_addr   = r_bus_addr;

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill: a cycle-stepped bus responder drives the fills,
// and results are compared against hand-computed addresses, cycles and line images.
module tb_cache_line_fill;

    logic         i_clk = 1'b0;
    logic         i_nreset;
    logic         i_req;
    logic [31:0]  i_req_addr;
    logic         o_req_ack;
    logic         o_cw_valid;
    logic [31:0]  o_cw_data;
    logic         o_line_valid;
    logic         o_line_err;
    logic [27:0]  o_line_addr;
    logic [127:0] o_line_data;
    logic         o_bus_req;
    logic [31:0]  o_bus_addr;
    logic         i_bus_ack;
    logic         i_bus_err;
    logic [31:0]  i_bus_data;

    cache_line_fill #(.TIMEOUT(4)) u_dut (
        .i_clk        (i_clk),
        .i_nreset     (i_nreset),
        .i_req        (i_req),
        .i_req_addr   (i_req_addr),
        .o_req_ack    (o_req_ack),
        .o_cw_valid   (o_cw_valid),
        .o_cw_data    (o_cw_data),
        .o_line_valid (o_line_valid),
        .o_line_err   (o_line_err),
        .o_line_addr  (o_line_addr),
        .o_line_data  (o_line_data),
        .o_bus_req    (o_bus_req),
        .o_bus_addr   (o_bus_addr),
        .i_bus_ack    (i_bus_ack),
        .i_bus_err    (i_bus_err),
        .i_bus_data   (i_bus_data)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    int          ack_cyc, cw_cyc, cw_cnt, lv_cyc, le_cyc;
    logic [31:0] cw_dat;
    logic [31:0] addr_seen [4];
    logic [31:0] dq [4];
    bit          stable_ok, breq_done, fill_done;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_data(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
        dq[0] = a; dq[1] = b; dq[2] = c; dq[3] = d;
    endtask

    // Called just after an edge (cycle 0); steps until LINE_VALID/LINE_ERR or the budget.
    task automatic run_fill(input logic [31:0] addr, input int waits, input int err_word,
                            input int stall_word, input bit hold, input logic [31:0] next_addr);
        int cyc, nacks, wcnt;
        logic [31:0] prev_addr;
        ack_cyc = -1; cw_cyc = -1; cw_cnt = 0; lv_cyc = -1; le_cyc = -1;
        cw_dat = '0; stable_ok = 1; breq_done = 1; fill_done = 0;
        for (int i = 0; i < 4; i++) addr_seen[i] = '0;
        cyc = 0; nacks = 0; wcnt = 0; prev_addr = '0;
        i_req = 1'b1;
        i_req_addr = addr;
        for (int k = 0; k < 60 && !fill_done; k++) begin
            tick();
            cyc++;
            if (o_req_ack && ack_cyc < 0) begin
                ack_cyc = cyc;
                if (hold) i_req_addr = next_addr;
                else i_req = 1'b0;
            end
            if (o_cw_valid) begin
                cw_cnt++;
                cw_cyc = cyc;
                cw_dat = o_cw_data;
            end
            if (o_line_valid) lv_cyc = cyc;
            if (o_line_err) le_cyc = cyc;
            i_bus_ack = 1'b0;
            i_bus_err = 1'b0;
            if (o_line_valid || o_line_err) begin
                fill_done = 1;
                breq_done = !o_bus_req;
            end else if (o_bus_req) begin
                if (wcnt > 0 && o_bus_addr != prev_addr) stable_ok = 0;
                prev_addr = o_bus_addr;
                if (nacks == stall_word || wcnt < waits) begin
                    wcnt++;
                end else begin
                    addr_seen[nacks] = o_bus_addr;
                    i_bus_ack  = 1'b1;
                    i_bus_data = dq[nacks];
                    if (nacks == err_word) i_bus_err = 1'b1;
                    nacks++;
                    wcnt = 0;
                end
            end
        end
        if (!fill_done) chk("fill_timeout", 0, 1);
    endtask

    initial begin
        bit seen;
        i_nreset = 1'b0; i_req = 1'b0; i_req_addr = '0;
        i_bus_ack = 1'b0; i_bus_err = 1'b0; i_bus_data = '0;
        repeat (2) tick();
        chk("rst_ctrl", {o_req_ack, o_cw_valid, o_line_valid, o_line_err, o_bus_req}, 5'b0);
        chk("rst_data", {o_bus_addr, o_cw_data, o_line_addr}, '0);
        chk("rst_line", o_line_data, '0);
        i_nreset = 1'b1;
        tick();

        // zero-wait fill, critical word 2
        set_data(32'hA, 32'hB, 32'hC, 32'hD);
        run_fill(32'h0001_2348, 0, -1, -1, 0, '0);
        chk("zw_ack_cyc", ack_cyc, 1);
        chk("zw_addr0", addr_seen[0], 32'h0001_2348);
        chk("zw_addr1", addr_seen[1], 32'h0001_234C);
        chk("zw_addr2", addr_seen[2], 32'h0001_2340);
        chk("zw_addr3", addr_seen[3], 32'h0001_2344);
        chk("zw_cw_cyc", cw_cyc, 2);
        chk("zw_cw_data", cw_dat, 32'hA);
        chk("zw_cw_cnt", cw_cnt, 1);
        chk("zw_lv_cyc", lv_cyc, 5);
        chk("zw_le", le_cyc, -1);
        chk("zw_line", o_line_data, {32'hC, 32'hD, 32'hA, 32'hB});
        chk("zw_laddr", o_line_addr, 28'h000_1234);
        chk("zw_breq_off", breq_done, 1);

        // acks while the bus is idle must be ignored
        seen = 0;
        i_bus_ack = 1'b1; i_bus_err = 1'b1; i_bus_data = 32'hDEAD;
        repeat (3) begin
            tick();
            seen |= o_cw_valid | o_line_valid | o_line_err | o_bus_req | o_req_ack;
        end
        i_bus_ack = 1'b0; i_bus_err = 1'b0;
        chk("idle_ack_ignored", seen, 0);

        // two wait states per word
        set_data(32'h1, 32'h2, 32'h3, 32'h4);
        run_fill(32'h0000_0100, 2, -1, -1, 0, '0);
        chk("ws_lv_cyc", lv_cyc, 13);
        chk("ws_cw_cyc", cw_cyc, 4);
        chk("ws_stable", stable_ok, 1);
        chk("ws_line", o_line_data, {32'h1, 32'h2, 32'h3, 32'h4});
        chk("ws_laddr", o_line_addr, 28'h000_0010);

        // error on third word with ack also high
        set_data(32'h7, 32'h8, 32'h9, 32'hA);
        run_fill(32'h0001_2348, 0, 2, -1, 0, '0);
        chk("err_le_cyc", le_cyc, 4);
        chk("err_no_lv", lv_cyc, -1);
        chk("err_breq_off", breq_done, 1);
        chk("err_cw_cnt", cw_cnt, 1);
        set_data(32'h31, 32'h32, 32'h33, 32'h34);
        run_fill(32'h2000_000C, 0, -1, -1, 0, '0);
        chk("after_err_lv", lv_cyc, 5);
        chk("after_err_line", o_line_data, {32'h32, 32'h33, 32'h34, 32'h31});

        // timeout on the first word
        run_fill(32'h0000_0040, 0, -1, 0, 0, '0);
        chk("to_le_cyc", le_cyc, 5);
        chk("to_cw_cnt", cw_cnt, 0);
        chk("to_no_lv", lv_cyc, -1);
        chk("to_stable", stable_ok, 1);

        // held request: address changes during fetch do not disturb the first fill
        set_data(32'h11, 32'h12, 32'h13, 32'h14);
        run_fill(32'h0000_0050, 0, -1, -1, 1, 32'h0000_006C);
        chk("hold_lv1", lv_cyc, 5);
        chk("hold_laddr1", o_line_addr, 28'h000_0005);
        chk("hold_line1", o_line_data, {32'h11, 32'h12, 32'h13, 32'h14});
        set_data(32'h21, 32'h22, 32'h23, 32'h24);
        run_fill(32'h0000_006C, 0, -1, -1, 0, '0);
        chk("hold_ack2", ack_cyc, 1);
        chk("hold_laddr2", o_line_addr, 28'h000_0006);
        chk("hold_line2", o_line_data, {32'h22, 32'h23, 32'h24, 32'h21});

        // reset while the second word is outstanding
        i_req = 1'b1; i_req_addr = 32'h0000_0A04;
        tick();
        i_req = 1'b0; i_bus_ack = 1'b1; i_bus_data = 32'h5;
        tick();
        i_bus_ack = 1'b0; i_nreset = 1'b0;
        tick();
        chk("mrst_ctrl", {o_req_ack, o_cw_valid, o_line_valid, o_line_err, o_bus_req}, 5'b0);
        chk("mrst_data", {o_bus_addr, o_cw_data, o_line_addr}, '0);
        chk("mrst_line", o_line_data, '0);
        i_nreset = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            seen |= o_line_valid | o_line_err | o_bus_req;
        end
        chk("mrst_quiet", seen, 0);
        set_data(32'hE1, 32'hE2, 32'hE3, 32'hE4);
        run_fill(32'h0000_0A04, 0, -1, -1, 0, '0);
        chk("mrst_lv", lv_cyc, 5);
        chk("mrst_line", o_line_data, {32'hE4, 32'hE1, 32'hE2, 32'hE3});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_line_fill.md
# cache_line_fill

Memory-side line fill engine for the 16KB 4-way instruction and data caches (256 sets, 16-byte lines, 20-bit tag). On a cache miss it accepts a line request, performs four 32-bit bus reads in critical-word-first wrap order, forwards the critical word early, and returns the assembled 128-bit line in cache-line order (L0 at the top) for the cache to install in its PLRU-selected way. It is the other end of the cache miss interface: the cache initiates, this block responds and masters the memory bus.

## Interface

Parameters:
- TIMEOUT, 255: maximum cycles a single bus read may wait for BUS_ACK/BUS_ERR; 0 disables the timeout.

Ports:
- CLK  in  1  clock; all logic on rising edge
- nRESET  in  1  synchronous, active-low reset
- REQ  in  1  miss request; held by cache until REQ_ACK
- REQ_ADDR  in  32  miss byte address; [31:4] line, [3:2] critical word, [1:0] ignored
- REQ_ACK  out  1  one-cycle pulse: request accepted
- CW_VALID  out  1  one-cycle pulse: critical word on CW_DATA
- CW_DATA  out  32  critical longword
- LINE_VALID  out  1  one-cycle pulse: full line on LINE_ADDR/LINE_DATA
- LINE_ERR  out  1  one-cycle pulse: fill aborted (bus error or timeout)
- LINE_ADDR  out  28  line address, REQ_ADDR[31:4] of the accepted request
- LINE_DATA  out  128  L0 [127:96], L1 [95:64], L2 [63:32], L3 [31:0]
- BUS_REQ  out  1  bus read strobe
- BUS_ADDR  out  32  longword-aligned read address ([1:0] = 0)
- BUS_ACK  in  1  read data valid on BUS_DATA
- BUS_ERR  in  1  read failed
- BUS_DATA  in  32  read data

## Operation

- States: IDLE, FETCH. All outputs registered.
- IDLE: if REQ=1, latch REQ_ADDR[31:4] into LINE_ADDR, set word pointer to REQ_ADDR[3:2], remaining count 3, go to FETCH. At the same edge: REQ_ACK=1, BUS_REQ=1, BUS_ADDR={REQ_ADDR[31:4], REQ_ADDR[3:2], 2'b00}.
- FETCH: BUS_REQ stays high. BUS_ADDR is stable until BUS_ACK or BUS_ERR is sampled.
  - BUS_ACK (and not BUS_ERR): write BUS_DATA into LINE_DATA slot selected by the word pointer. Pointer increments modulo 4 (wrap 3 to 0), and BUS_ADDR advances at the same edge, so reads are back-to-back. On the first ack, CW_DATA=BUS_DATA and CW_VALID=1.
  - Fourth ack: LINE_VALID=1, BUS_REQ=0, go to IDLE.
  - BUS_ERR (takes precedence over a simultaneous BUS_ACK): LINE_ERR=1, BUS_REQ=0, go to IDLE, no LINE_VALID. If the error hits the first word, CW_VALID is not asserted.
  - Timeout: a wait counter clears at each new word and increments each cycle without ACK/ERR. When the count reaches TIMEOUT (TIMEOUT>0), the fill is handled as BUS_ERR.
- REQ is ignored in FETCH. REQ is sampled again in IDLE, so a held REQ starts a new fill one cycle after LINE_VALID/LINE_ERR.
- BUS_ACK/BUS_ERR are ignored while BUS_REQ=0.
- LINE_DATA and LINE_ADDR keep their last values until the next accepted request; LINE_DATA is meaningful only when LINE_VALID=1.

## Timing

- Reset (nRESET=0 at an edge): state IDLE; REQ_ACK, CW_VALID, LINE_VALID, LINE_ERR, BUS_REQ = 0; BUS_ADDR, CW_DATA, LINE_ADDR, LINE_DATA = 0; counters 0. Reset mid-FETCH aborts immediately with no LINE_VALID or LINE_ERR pulse.
- Zero-wait bus (ACK on every BUS_REQ cycle), REQ high in cycle 0:
  - cycle 1: REQ_ACK, BUS_REQ, critical-word address
  - cycles 1–4: four acks
  - cycle 2: CW_VALID
  - cycle 5: LINE_VALID, state IDLE
  - earliest next REQ_ACK: cycle 6
- With wait states, each word adds its wait cycles. Minimum fill is 5 cycles from request to line.
- REQ_ACK, CW_VALID, LINE_VALID and LINE_ERR are always single-cycle. LINE_VALID and LINE_ERR are never high together.

## Test plan

- Zero-wait fill, REQ_ADDR=0x0001_2348:
  - BUS_ADDR sequence 0x12348, 0x1234C, 0x12340, 0x12344, returning 0xA, 0xB, 0xC, 0xD
  - CW_DATA=0xA at cycle 2
  - LINE_DATA={0xC,0xD,0xA,0xB} (L0..L3), LINE_ADDR=0x0001234, LINE_VALID at cycle 5
- Wait states: 2 idle cycles before each ACK on REQ_ADDR=0x100 -> BUS_ADDR held stable; LINE_VALID at cycle 13; line in order L0..L3.
- BUS_ERR on third word, ACK also high -> LINE_ERR pulse, no LINE_VALID, BUS_REQ low next cycle, IDLE; a new REQ is accepted afterwards.
- TIMEOUT=4, no ACK on first word -> LINE_ERR after 4 waiting cycles; CW_VALID never asserted.
- REQ held continuously with two addresses -> second REQ_ACK exactly one cycle after first LINE_VALID; REQ changes during FETCH are ignored.
- nRESET=0 during second word -> all outputs 0 next cycle; no LINE_VALID or LINE_ERR; a subsequent fill completes normally.
